// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/response bundle between the fetch-stage control
// logic (master) and the program-counter sequencer (slave).
//   Requests : Stall, ExcTaken/ExcVec, BrTaken/BrTarget, Jump, Call,
//              JumpTarget, Ret
//   Responses: PC, IncPC1, RasCount, RasOverflow, RasUnderflow
interface pc_sequencer_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic             Stall;
  logic             ExcTaken;
  logic [WIDTH-1:0] ExcVec;
  logic             BrTaken;
  logic [WIDTH-1:0] BrTarget;
  logic             Jump;
  logic             Call;
  logic [WIDTH-1:0] JumpTarget;
  logic             Ret;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] IncPC1;
  logic [CW-1:0]    RasCount;
  logic             RasOverflow;
  logic             RasUnderflow;

  modport master (
    output Stall, ExcTaken, ExcVec, BrTaken, BrTarget, Jump, Call, JumpTarget, Ret,
    input  PC, IncPC1, RasCount, RasOverflow, RasUnderflow
  );

  modport slave (
    input  Stall, ExcTaken, ExcVec, BrTaken, BrTarget, Jump, Call, JumpTarget, Ret,
    output PC, IncPC1, RasCount, RasOverflow, RasUnderflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with a circular return-address
// stack. Next PC is chosen by priority exception > branch > return >
// call/jump > sequential increment. Returns pop the RAS; calls push PC+STEP.
// Ports:
//   CLK  - rising-edge clock
//   RST  - synchronous active-high reset
//   bus  - pc_sequencer_if.slave (requests in, PC/IncPC1/RAS status out)
module pc_sequencer #(
  parameter int          WIDTH     = 32,
  parameter int          STEP      = 1,
  parameter longint unsigned RESET_VEC = 0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  pc_sequencer_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] RV   = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] STP  = WIDTH'(STEP);
  localparam logic [CW-1:0]    FULL = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    ptr;      // next free slot; top of stack is ptr-1
  logic [PW-1:0]    ptr_dec;
  logic [WIDTH-1:0] inc_pc;
  logic [WIDTH-1:0] nxt_pc;
  logic             do_push, do_pop, und;

  assign inc_pc  = bus.PC + STP;
  assign ptr_dec = ptr - 1'b1;

  // Unstalled, non-exception next-PC selection. Losing requests produce no
  // RAS side effects because only the winning branch raises do_push/do_pop.
  always_comb begin
    nxt_pc  = inc_pc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    und     = 1'b0;
    if (bus.BrTaken) begin
      nxt_pc = bus.BrTarget;
    end else if (bus.Ret) begin
      if (bus.RasCount == '0) begin
        und = 1'b1;
      end else begin
        do_pop = 1'b1;
        nxt_pc = ras[ptr_dec];
      end
    end else if (bus.Call) begin
      do_push = 1'b1;
      nxt_pc  = bus.JumpTarget;
    end else if (bus.Jump) begin
      nxt_pc = bus.JumpTarget;
    end
  end

  // RAS entries are deliberately not cleared on reset: RasCount=0 makes them
  // unreachable, so only the pointer and count need resetting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.PC           <= RV;
      bus.IncPC1       <= RV + STP;
      ptr              <= '0;
      bus.RasCount     <= '0;
      bus.RasOverflow  <= 1'b0;
      bus.RasUnderflow <= 1'b0;
    end else begin
      bus.RasUnderflow <= 1'b0;
      if (bus.ExcTaken) begin
        // Exception beats stall and leaves the RAS alone.
        bus.PC     <= bus.ExcVec;
        bus.IncPC1 <= inc_pc;
      end else if (!bus.Stall) begin
        bus.PC           <= nxt_pc;
        bus.IncPC1       <= inc_pc;
        bus.RasUnderflow <= und;
        if (do_push) begin
          ras[ptr] <= inc_pc;
          ptr      <= ptr + 1'b1;
          // When full, the write lands on the oldest entry (ptr wrapped onto it).
          if (bus.RasCount == FULL) bus.RasOverflow <= 1'b1;
          else                      bus.RasCount    <= bus.RasCount + 1'b1;
        end
        if (do_pop) begin
          ptr          <= ptr_dec;
          bus.RasCount <= bus.RasCount - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (32-bit/STEP=4/RESET_VEC=0x100 and
// 8-bit/STEP=1/RESET_VEC=0x10) driven by directed scenarios and random
// stimulus, checked against a shifting-stack reference model.
module tb_pc_sequencer;
  typedef struct packed {
    logic        stall, exc, br, jump, call, ret;
    logic [31:0] excvec, brt, jt;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_t rq [2];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  logic [31:0] m_pc [2];
  logic [31:0] m_inc [2];
  logic [31:0] m_stk [2][4];
  int          m_cnt [2];
  logic        m_ovf [2];
  logic        m_und [2];
  logic [31:0] msk [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] stp [2] = '{32'd4, 32'd1};
  logic [31:0] rvec [2] = '{32'h100, 32'h10};

  pc_sequencer_if #(.WIDTH(32), .RAS_DEPTH(4)) ifa ();
  pc_sequencer_if #(.WIDTH(8),  .RAS_DEPTH(4)) ifb ();

  assign ifa.Stall = rq[0].stall;     assign ifb.Stall = rq[1].stall;
  assign ifa.ExcTaken = rq[0].exc;    assign ifb.ExcTaken = rq[1].exc;
  assign ifa.ExcVec = rq[0].excvec;   assign ifb.ExcVec = rq[1].excvec[7:0];
  assign ifa.BrTaken = rq[0].br;      assign ifb.BrTaken = rq[1].br;
  assign ifa.BrTarget = rq[0].brt;    assign ifb.BrTarget = rq[1].brt[7:0];
  assign ifa.Jump = rq[0].jump;       assign ifb.Jump = rq[1].jump;
  assign ifa.Call = rq[0].call;       assign ifb.Call = rq[1].call;
  assign ifa.JumpTarget = rq[0].jt;   assign ifb.JumpTarget = rq[1].jt[7:0];
  assign ifa.Ret = rq[0].ret;         assign ifb.Ret = rq[1].ret;

  pc_sequencer #(.WIDTH(32), .STEP(4), .RESET_VEC(64'h100), .RAS_DEPTH(4))
    dut_a (.CLK(clk), .RST(rst), .bus(ifa));
  pc_sequencer #(.WIDTH(8), .STEP(1), .RESET_VEC(64'h10), .RAS_DEPTH(4))
    dut_b (.CLK(clk), .RST(rst), .bus(ifb));

  // One cycle of the architectural rules, using a stack that shifts out its
  // oldest element when a push arrives while full.
  task automatic model_step(int i);
    logic [31:0] inc;
    inc = (m_pc[i] + stp[i]) & msk[i];
    m_und[i] = 1'b0;
    if (rst) begin
      m_pc[i] = rvec[i]; m_inc[i] = (rvec[i] + stp[i]) & msk[i];
      m_cnt[i] = 0; m_ovf[i] = 1'b0;
    end else if (rq[i].exc) begin
      m_pc[i] = rq[i].excvec & msk[i]; m_inc[i] = inc;
    end else if (!rq[i].stall) begin
      m_inc[i] = inc;
      if (rq[i].br) m_pc[i] = rq[i].brt & msk[i];
      else if (rq[i].ret) begin
        if (m_cnt[i] == 0) begin m_pc[i] = inc; m_und[i] = 1'b1; end
        else begin m_cnt[i]--; m_pc[i] = m_stk[i][m_cnt[i]]; end
      end else if (rq[i].call) begin
        if (m_cnt[i] == 4) begin
          for (int k = 0; k < 3; k++) m_stk[i][k] = m_stk[i][k+1];
          m_stk[i][3] = inc; m_ovf[i] = 1'b1;
        end else begin
          m_stk[i][m_cnt[i]] = inc; m_cnt[i]++;
        end
        m_pc[i] = rq[i].jt & msk[i];
      end else if (rq[i].jump) m_pc[i] = rq[i].jt & msk[i];
      else m_pc[i] = inc;
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] prev;
    rq[0] = '0; rq[1] = '0; rst = 1'b1;
    tick();
    n_tests++; if (ifa.PC !== 32'h100) begin n_fail++; $display("FAIL reset_pc got %h want 100", ifa.PC); end
    n_tests++; if (ifa.IncPC1 !== 32'h104) begin n_fail++; $display("FAIL reset_incpc1 got %h want 104", ifa.IncPC1); end
    n_tests++; if (ifa.RasCount !== 3'd0 || ifa.RasOverflow !== 1'b0 || ifa.RasUnderflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_ras got cnt=%0d ovf=%b und=%b want 0/0/0", ifa.RasCount, ifa.RasOverflow, ifa.RasUnderflow); end
    n_tests++; if (ifb.PC !== 8'h10) begin n_fail++; $display("FAIL reset_pc_b got %h want 10", ifb.PC); end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      prev = ifa.PC;
      tick();
      n_tests++; if (ifa.PC !== 32'h100 + 32'(4*k)) begin n_fail++; $display("FAIL incr_pc%0d got %h want %h", k, ifa.PC, 32'h100 + 32'(4*k)); end
      n_tests++; if (ifa.IncPC1 !== prev + 32'd4) begin n_fail++; $display("FAIL incr_incpc1_%0d got %h want %h", k, ifa.IncPC1, prev + 32'd4); end
    end
  endtask

  task automatic test_priority();
    rq[0] = '0; rq[0].jump = 1'b1; rq[0].jt = 32'h20;
    tick();
    n_tests++; if (ifa.PC !== 32'h20) begin n_fail++; $display("FAIL prio_jump got %h want 20", ifa.PC); end
    rq[0] = '0; rq[0].exc = 1'b1; rq[0].excvec = 32'h80; rq[0].br = 1'b1; rq[0].brt = 32'h40;
    rq[0].call = 1'b1; rq[0].jt = 32'h60;
    tick();
    n_tests++; if (ifa.PC !== 32'h80 || ifa.RasCount !== 3'd0) begin
      n_fail++; $display("FAIL prio_exc got pc=%h cnt=%0d want 80/0", ifa.PC, ifa.RasCount); end
    rq[0] = '0; rq[0].br = 1'b1; rq[0].brt = 32'h40; rq[0].jump = 1'b1; rq[0].jt = 32'h60;
    tick();
    n_tests++; if (ifa.PC !== 32'h40) begin n_fail++; $display("FAIL prio_br got %h want 40", ifa.PC); end
  endtask

  task automatic test_stall();
    rq[0] = '0; rq[0].stall = 1'b1; rq[0].br = 1'b1; rq[0].brt = 32'h200;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (ifa.PC !== 32'h40 || ifa.IncPC1 !== 32'h84) begin
        n_fail++; $display("FAIL stall_hold%0d got pc=%h inc=%h want 40/84", k, ifa.PC, ifa.IncPC1); end
    end
    rq[0].br = 1'b0; rq[0].exc = 1'b1; rq[0].excvec = 32'h300;
    tick();
    n_tests++; if (ifa.PC !== 32'h300 || ifa.IncPC1 !== 32'h44) begin
      n_fail++; $display("FAIL stall_exc got pc=%h inc=%h want 300/44", ifa.PC, ifa.IncPC1); end
    rq[0] = '0;
  endtask

  task automatic test_call_ret();
    logic [7:0] exp_pc [4] = '{8'd50, 8'd90, 8'd51, 8'd6};
    int         exp_c  [4] = '{1, 2, 1, 0};
    rq[1] = '0; rq[1].jump = 1'b1; rq[1].jt = 32'd5;
    tick();
    for (int k = 0; k < 4; k++) begin
      rq[1] = '0;
      if (k == 0) begin rq[1].call = 1'b1; rq[1].jt = 32'd50; end
      else if (k == 1) begin rq[1].call = 1'b1; rq[1].jt = 32'd90; end
      else rq[1].ret = 1'b1;
      tick();
      n_tests++; if (ifb.PC !== exp_pc[k] || ifb.RasCount !== 3'(exp_c[k])) begin
        n_fail++; $display("FAIL nest%0d got pc=%0d cnt=%0d want %0d/%0d", k, ifb.PC, ifb.RasCount, exp_pc[k], exp_c[k]); end
    end
    rq[1] = '0;
  endtask

  task automatic test_overflow();
    rq[1] = '0; rq[1].jump = 1'b1; rq[1].jt = 32'd10;
    tick();
    for (int k = 0; k < 5; k++) begin
      rq[1] = '0; rq[1].call = 1'b1; rq[1].jt = 32'(20 + 10*k);
      tick();
    end
    n_tests++; if (ifb.RasCount !== 3'd4 || ifb.RasOverflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_state got cnt=%0d ovf=%b want 4/1", ifb.RasCount, ifb.RasOverflow); end
    for (int k = 0; k < 4; k++) begin
      rq[1] = '0; rq[1].ret = 1'b1;
      tick();
      n_tests++; if (ifb.PC !== 8'(51 - 10*k)) begin
        n_fail++; $display("FAIL ovf_ret%0d got %0d want %0d", k, ifb.PC, 51 - 10*k); end
    end
    tick();
    n_tests++; if (ifb.PC !== 8'd22 || ifb.RasUnderflow !== 1'b1 || ifb.RasCount !== 3'd0) begin
      n_fail++; $display("FAIL undf got pc=%0d und=%b cnt=%0d want 22/1/0", ifb.PC, ifb.RasUnderflow, ifb.RasCount); end
    rq[1] = '0;
    tick();
    n_tests++; if (ifb.PC !== 8'd23 || ifb.RasUnderflow !== 1'b0 || ifb.RasOverflow !== 1'b1) begin
      n_fail++; $display("FAIL undf_pulse got pc=%0d und=%b ovf=%b want 23/0/1", ifb.PC, ifb.RasUnderflow, ifb.RasOverflow); end
  endtask

  task automatic test_wrap_reset();
    rq[1] = '0; rq[1].jump = 1'b1; rq[1].jt = 32'hFF;
    tick();
    rq[1] = '0;
    tick();
    n_tests++; if (ifb.PC !== 8'h00 || ifb.IncPC1 !== 8'h00) begin
      n_fail++; $display("FAIL wrap got pc=%h inc=%h want 00/00", ifb.PC, ifb.IncPC1); end
    rq[1].call = 1'b1; rq[1].jt = 32'h30;
    tick();
    rq[1].jt = 32'h40; rst = 1'b1;
    tick();
    n_tests++; if (ifb.PC !== 8'h10 || ifb.RasCount !== 3'd0 || ifb.RasOverflow !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got pc=%h cnt=%0d ovf=%b want 10/0/0", ifb.PC, ifb.RasCount, ifb.RasOverflow); end
    rst = 1'b0; rq[1] = '0; rq[1].ret = 1'b1;
    tick();
    n_tests++; if (ifb.PC !== 8'h11 || ifb.RasUnderflow !== 1'b1) begin
      n_fail++; $display("FAIL rst_ras_gone got pc=%h und=%b want 11/1", ifb.PC, ifb.RasUnderflow); end
    rq[1] = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(79) == 0);
      for (int i = 0; i < 2; i++) begin
        rq[i].stall  = ($urandom_range(5) == 0);
        rq[i].exc    = ($urandom_range(15) == 0);
        rq[i].br     = ($urandom_range(7) == 0);
        rq[i].ret    = ($urandom_range(4) == 0);
        rq[i].call   = ($urandom_range(3) == 0);
        rq[i].jump   = ($urandom_range(9) == 0);
        rq[i].excvec = $urandom() & msk[i];
        rq[i].brt    = $urandom() & msk[i];
        rq[i].jt     = $urandom() & msk[i];
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        logic [31:0] po, io;
        logic [2:0]  co;
        logic        ov, un;
        if (i == 0) begin
          po = ifa.PC; io = ifa.IncPC1; co = ifa.RasCount; ov = ifa.RasOverflow; un = ifa.RasUnderflow;
        end else begin
          po = {24'h0, ifb.PC}; io = {24'h0, ifb.IncPC1}; co = ifb.RasCount;
          ov = ifb.RasOverflow; un = ifb.RasUnderflow;
        end
        n_tests++; if (po !== m_pc[i]) begin n_fail++; $display("FAIL rnd_pc u%0d c%0d got %h want %h", i, c, po, m_pc[i]); end
        n_tests++; if (io !== m_inc[i]) begin n_fail++; $display("FAIL rnd_inc u%0d c%0d got %h want %h", i, c, io, m_inc[i]); end
        n_tests++; if (co !== 3'(m_cnt[i])) begin n_fail++; $display("FAIL rnd_cnt u%0d c%0d got %0d want %0d", i, c, co, m_cnt[i]); end
        n_tests++; if (ov !== m_ovf[i]) begin n_fail++; $display("FAIL rnd_ovf u%0d c%0d got %b want %b", i, c, ov, m_ovf[i]); end
        n_tests++; if (un !== m_und[i]) begin n_fail++; $display("FAIL rnd_und u%0d c%0d got %b want %b", i, c, un, m_und[i]); end
      end
    end
    rst = 1'b0; rq[0] = '0; rq[1] = '0;
  endtask

  initial begin
    rq[0] = '0; rq[1] = '0;
    #2;
    test_reset();
    test_priority();
    test_stall();
    test_call_ret();
    test_overflow();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the fetch stage of the pipelined MIPS core. It generates the fetch address each cycle: sequential increment, exception vector, branch redirect, jump/call and return. Returns are predicted from an internal circular return-address stack (RAS). It supports stall, and its reset vector and increment step are configurable.

Parameters:
WIDTH, 32, address width in bits
STEP, 1, sequential increment (1 = word-addressed imem, 4 = byte-addressed)
RESET_VEC, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
Stall  in  1  hazard stall; freezes PC, IncPC1 and RAS
ExcTaken  in  1  exception redirect request
ExcVec  in  WIDTH  exception handler address
BrTaken  in  1  resolved branch/mispredict redirect
BrTarget  in  WIDTH  branch target
Jump  in  1  unconditional jump
Call  in  1  jump-and-link; push return address, go to JumpTarget
JumpTarget  in  WIDTH  jump/call target
Ret  in  1  return; pop RAS and go to popped address
PC  out  WIDTH  current fetch address (registered)
IncPC1  out  WIDTH  registered PC+STEP (link value for the fetched instruction)
RasCount  out  clog2(RAS_DEPTH)+1  valid RAS entries
RasOverflow  out  1  sticky; set when a push overwrites a valid entry
RasUnderflow  out  1  one-cycle pulse; set when Ret is taken with RAS empty

Behaviour:
- Reset (RST=1 at posedge; overrides all other inputs): PC=RESET_VEC, IncPC1=RESET_VEC+STEP, RasCount=0, RasOverflow=0, RasUnderflow=0, RAS pointer=0.
- Arithmetic: IncPC = PC+STEP, modulo 2^WIDTH. Wrap from all-ones is legal and silent.
- Next-PC priority, highest first:
  ExcTaken -> ExcVec
  BrTaken -> BrTarget
  Ret -> popped RAS top
  Call or Jump -> JumpTarget
  otherwise -> IncPC
- Lower-priority requests in the same cycle are discarded, including their RAS side effects.
- Stall=1 with ExcTaken=0: PC, IncPC1, RAS contents, pointer and RasCount hold. RasUnderflow drives 0.
- ExcTaken overrides Stall: PC loads ExcVec, IncPC1 updates, RAS is untouched.
- BrTaken does not override Stall: it is ignored while Stall=1.
- Latency: a request sampled at posedge N appears on PC after posedge N (one cycle). IncPC1 <= IncPC on every unstalled edge.
- RAS push (Call, when it wins priority):
  - write IncPC at top pointer; pointer increments modulo RAS_DEPTH
  - RasCount saturates at RAS_DEPTH
  - a push when RasCount==RAS_DEPTH overwrites the oldest entry and sets RasOverflow; RasOverflow stays set until RST
- RAS pop (Ret, when it wins priority):
  - pointer decrements modulo RAS_DEPTH; next PC = entry at the decremented pointer; RasCount decrements
  - Ret with RasCount==0: next PC = IncPC, pointer and count unchanged, RasUnderflow pulses 1 for one cycle
- Call and Ret both asserted: Ret wins, no push.
- Reset mid-sequence discards all RAS contents; entries are not cleared, but RasCount=0 makes them unreachable.

Test Plan:
- Reset/increment: WIDTH=32, STEP=4, RESET_VEC=0x100; release RST, idle 3 cycles -> PC 0x100, 0x104, 0x108, 0x10C; IncPC1 lags PC by one cycle (equals previous PC+4).
- Priority: at PC=0x20 assert ExcTaken(ExcVec=0x80), BrTaken(0x40) and Call(0x60) together -> next PC=0x80, RasCount stays 0; then BrTaken+Jump -> BrTarget.
- Stall: Stall=1 for 3 cycles with BrTaken=1 -> PC frozen; Stall=1 with ExcTaken=1 -> PC=ExcVec next cycle.
- Call/return nesting (STEP=1): Call at PC=5 (target 50), Call at 50 (target 90), Ret, Ret -> PC 50, 90, 51, 6; RasCount 1, 2, 1, 0.
- RAS overflow/underflow (RAS_DEPTH=4): 5 Calls -> RasCount=4, RasOverflow=1, 4 Rets return the 4 newest addresses. Fifth Ret -> PC=PC+STEP, RasUnderflow=1 for one cycle.
- Wrap: WIDTH=8, STEP=1, PC=0xFF -> next PC 0x00; RST asserted during an active Call chain -> PC=RESET_VEC, RasCount=0, RasOverflow=0.
